// File: rtl/ula_fl_arb.sv
// Round-robin arbiter that shares one multicycle floating-point ALU among NREQ requesters.
// Optional opcode check (12..15 rejected with err pulse) is enabled by defining ULA_FL_ARB_OPCHK_EN.
module ula_fl_arb #(
    parameter int NREQ = 4,
    parameter int EXP  = 8,
    parameter int MAN  = 23,
    parameter int LAT  = 1,
    localparam int W   = MAN + EXP + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_in1,
    input  logic [W*NREQ-1:0]   req_in2,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [W-1:0]        res,
    output logic                busy,
    output logic [3:0]          alu_op,
    output logic [W-1:0]        alu_in1,
    output logic [W-1:0]        alu_in2,
    input  logic [W-1:0]        alu_out
`ifdef ULA_FL_ARB_OPCHK_EN
    ,
    output logic                err
`endif
);

    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   idx;
    logic [3:0]      cnt;

    logic            sel_hit;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] sel_oh;
    logic [3:0]      sel_op;
    logic [W-1:0]    sel_in1;
    logic [W-1:0]    sel_in2;

    // Scan starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
        sel_hit = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = PW'((int'(ptr) + off) % NREQ);
            if (!sel_hit && req[cand]) begin
                sel_hit = 1'b1;
                sel_idx = cand;
            end
        end
        sel_oh          = '0;
        sel_oh[sel_idx] = 1'b1;
        sel_op          = req_op[4*int'(sel_idx) +: 4];
        sel_in1         = req_in1[W*int'(sel_idx) +: W];
        sel_in2         = req_in2[W*int'(sel_idx) +: W];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            res     <= '0;
            busy    <= 1'b0;
            alu_op  <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
`ifdef ULA_FL_ARB_OPCHK_EN
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_hit) begin
                        gnt  <= sel_oh;
                        idx  <= sel_idx;
                        busy <= 1'b1;
`ifdef ULA_FL_ARB_OPCHK_EN
                        if (sel_op >= 4'd12) begin
                            // Rejected opcode bypasses the ALU and answers immediately.
                            res   <= '0;
                            done  <= sel_oh;
                            err   <= 1'b1;
                            state <= RESP;
                        end else
`endif
                        begin
                            alu_op  <= sel_op;
                            alu_in1 <= sel_in1;
                            alu_in2 <= sel_in2;
                            cnt     <= 4'(LAT);
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd1) begin
                        res   <= alu_out;
                        done  <= gnt;
                        cnt   <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    gnt    <= '0;
                    done   <= '0;
                    busy   <= 1'b0;
                    alu_op <= '0;
                    ptr    <= (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
`ifdef ULA_FL_ARB_OPCHK_EN
                    err    <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
